// File: rtl/proj_pkg.sv
// ---------------------------------------------------------------------------
// proj_pkg
// Shared types and constants for the projectile controller. The player-motion
// stage uses the same screen bounds and key codes.
//   dir_e          : DIR_LEFT = 0, DIR_RIGHT = 1
//   slot_state_e   : per-slot flight state
//   KEY_*          : keyboard scan codes
//   X_MIN / X_MAX  : legal projectile X range, inclusive
//   clamp_x()      : limits an 11-bit spawn X to X_MAX
// ---------------------------------------------------------------------------
package proj_pkg;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_FLY  = 1'b1
  } slot_state_e;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] SHOOT_KEY = KEY_SPACE;

  localparam int unsigned NUM_PROJ       = 4;
  localparam int unsigned PROJ_SPEED     = 12;
  localparam int unsigned COOLDOWN       = 8;
  localparam int unsigned X_MIN          = 0;
  localparam int unsigned X_MAX          = 639;
  localparam int unsigned SPAWN_X_OFFSET = 32;
  localparam int unsigned SPAWN_Y_OFFSET = 16;

  localparam int unsigned POS_W = 10;
  localparam int unsigned CD_W  = $clog2(COOLDOWN + 1);

  // A spawn point past the right edge is pulled back onto the screen rather
  // than being rejected, so the shot is never silently lost.
  function automatic logic [POS_W-1:0] clamp_x(input logic [POS_W:0] x_wide);
    if (x_wide > (POS_W + 1)'(X_MAX)) begin
      return POS_W'(X_MAX);
    end
    return x_wide[POS_W-1:0];
  endfunction

endpackage

// File: rtl/proj_slot.sv
// ---------------------------------------------------------------------------
// proj_slot
// One projectile slot. Loads position and direction on spawn, moves
// PROJ_SPEED pixels per frame in its latched direction and retires when the
// next position leaves [X_MIN, X_MAX].
// Ports:
//   frame_clk, Reset        : frame clock, synchronous active-high reset
//   spawn                   : allocate this slot this frame (only honoured in IDLE)
//   spawn_x, spawn_y        : spawn position
//   spawn_dir               : direction latched at spawn
//   active                  : slot is in flight
//   x, y                    : current position (held after retirement)
// ---------------------------------------------------------------------------
module proj_slot
  import proj_pkg::*;
(
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             spawn,
  input  logic [POS_W-1:0] spawn_x,
  input  logic [POS_W-1:0] spawn_y,
  input  dir_e             spawn_dir,
  output logic             active,
  output logic [POS_W-1:0] x,
  output logic [POS_W-1:0] y
);

  slot_state_e      state_q, state_d;
  logic [POS_W-1:0] x_q, x_d;
  logic [POS_W-1:0] y_q, y_d;
  dir_e             dir_q, dir_d;

  logic [POS_W+1:0] next_ext;
  logic             out_of_range;

  // The move is computed with one bit beyond the 11-bit position sum so that a
  // leftward underflow shows up as a negative value instead of wrapping to a
  // large positive one; both cases land outside the legal range.
  always_comb begin
    if (dir_q == DIR_RIGHT) begin
      next_ext = {2'b00, x_q} + (POS_W + 2)'(PROJ_SPEED);
    end else begin
      next_ext = {2'b00, x_q} - (POS_W + 2)'(PROJ_SPEED);
    end
    out_of_range = ($signed(next_ext) < $signed((POS_W + 2)'(X_MIN))) ||
                   ($signed(next_ext) > $signed((POS_W + 2)'(X_MAX)));
  end

  // A slot spawned this frame only loads; its first move is the next frame.
  // On retirement x and y keep their last on-screen values.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    case (state_q)
      SLOT_IDLE: begin
        if (spawn) begin
          state_d = SLOT_FLY;
          x_d     = spawn_x;
          y_d     = spawn_y;
          dir_d   = spawn_dir;
        end
      end
      SLOT_FLY: begin
        if (out_of_range) begin
          state_d = SLOT_IDLE;
        end else begin
          x_d = next_ext[POS_W-1:0];
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= SLOT_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= DIR_RIGHT;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
    end
  end

  assign active = (state_q == SLOT_FLY);
  assign x      = x_q;
  assign y      = y_q;

endmodule

// File: rtl/proj_ctrl.sv
// ---------------------------------------------------------------------------
// proj_ctrl
// Projectile controller. Tracks facing, turns shoot-key presses into fire
// requests, enforces the cooldown, allocates the lowest free slot and counts
// accepted shots. Slot motion lives in proj_slot.
// Build option: define PROJ_AUTOFIRE_EN to make the fire request follow the
// key level (holding the key fires every time cooldown allows); by default a
// request needs a fresh key press.
// Ports:
//   frame_clk, Reset        : frame clock, synchronous active-high reset
//   keycodeshoot            : shoot key channel
//   keycode_dir             : movement key channel (A = left, D = right)
//   Ball_X, Ball_Y          : player position
//   proj_active             : per-slot in-flight flags
//   proj_x, proj_y          : packed positions, slot i at [10i+9:10i]
//   facing                  : 1 = right, 0 = left
//   shot_fired              : one-frame pulse on an accepted spawn
//   shot_count              : accepted shots, wraps at 256
// ---------------------------------------------------------------------------
module proj_ctrl
  import proj_pkg::*;
(
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [7:0]                keycodeshoot,
  input  logic [7:0]                keycode_dir,
  input  logic [POS_W-1:0]          Ball_X,
  input  logic [POS_W-1:0]          Ball_Y,
  output logic [NUM_PROJ-1:0]       proj_active,
  output logic [NUM_PROJ*POS_W-1:0] proj_x,
  output logic [NUM_PROJ*POS_W-1:0] proj_y,
  output logic                      facing,
  output logic                      shot_fired,
  output logic [7:0]                shot_count
);

  dir_e             facing_q, facing_d;
  logic [CD_W-1:0]  cooldown_q, cooldown_d;
  logic             shot_fired_q, shot_fired_d;
  logic [7:0]       shot_count_q, shot_count_d;

  logic             shoot_now;
  logic             fire_req;
  logic             accept;
  logic [NUM_PROJ-1:0] alloc;
  logic [POS_W-1:0] spawn_x;
  logic [POS_W-1:0] spawn_y;

`ifndef PROJ_AUTOFIRE_EN
  logic             shoot_prev_q, shoot_prev_d;
`endif

  assign shoot_now = (keycodeshoot == SHOOT_KEY);

  // Facing follows the direction key this frame so a shot fired on the same
  // frame as a turn already goes the new way.
  always_comb begin
    facing_d = facing_q;
    if (keycode_dir == KEY_A) begin
      facing_d = DIR_LEFT;
    end else if (keycode_dir == KEY_D) begin
      facing_d = DIR_RIGHT;
    end
  end

`ifdef PROJ_AUTOFIRE_EN
  assign fire_req = shoot_now;
`else
  assign fire_req     = shoot_now && !shoot_prev_q;
  assign shoot_prev_d = shoot_now;
`endif

  // Lowest-index free slot wins. This looks at the registered active flags,
  // so a slot retiring on this edge is not reused until the following frame.
  always_comb begin
    alloc = '0;
    for (int i = int'(NUM_PROJ) - 1; i >= 0; i--) begin
      if (!proj_active[i]) begin
        alloc    = '0;
        alloc[i] = 1'b1;
      end
    end
  end

  assign accept = fire_req && (cooldown_q == '0) && (|alloc);

  // Spawn point sits ahead of the player when facing right; facing left it
  // starts at the player origin.
  always_comb begin
    if (facing_d == DIR_RIGHT) begin
      spawn_x = clamp_x({1'b0, Ball_X} + (POS_W + 1)'(SPAWN_X_OFFSET));
    end else begin
      spawn_x = clamp_x({1'b0, Ball_X});
    end
    spawn_y = Ball_Y + POS_W'(SPAWN_Y_OFFSET);
  end

  // Rejected requests leave the cooldown alone; an accepted one reloads it.
  always_comb begin
    cooldown_d   = cooldown_q;
    shot_fired_d = accept;
    shot_count_d = shot_count_q;
    if (accept) begin
      cooldown_d   = CD_W'(COOLDOWN);
      shot_count_d = shot_count_q + 8'd1;
    end else if (cooldown_q != '0) begin
      cooldown_d = cooldown_q - CD_W'(1);
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      facing_q     <= DIR_RIGHT;
      cooldown_q   <= '0;
      shot_fired_q <= 1'b0;
      shot_count_q <= '0;
    end else begin
      facing_q     <= facing_d;
      cooldown_q   <= cooldown_d;
      shot_fired_q <= shot_fired_d;
      shot_count_q <= shot_count_d;
    end
  end

`ifndef PROJ_AUTOFIRE_EN
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      shoot_prev_q <= 1'b0;
    end else begin
      shoot_prev_q <= shoot_prev_d;
    end
  end
`endif

  for (genvar g = 0; g < int'(NUM_PROJ); g++) begin : g_slot
    proj_slot u_slot (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .spawn     (accept && alloc[g]),
      .spawn_x   (spawn_x),
      .spawn_y   (spawn_y),
      .spawn_dir (facing_d),
      .active    (proj_active[g]),
      .x         (proj_x[POS_W*g +: POS_W]),
      .y         (proj_y[POS_W*g +: POS_W])
    );
  end

  assign facing     = (facing_q == DIR_RIGHT);
  assign shot_fired = shot_fired_q;
  assign shot_count = shot_count_q;

endmodule

// File: tb/tb_proj_ctrl.sv
// ---------------------------------------------------------------------------
// tb_proj_ctrl
// Self-checking bench for proj_ctrl. A frame-level behavioural model (plain
// integer arrays) is stepped alongside the DUT; directed scenarios add fixed
// expected values, then randomized frames run against the model.
// Honours PROJ_AUTOFIRE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_proj_ctrl;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycodeshoot;
  logic [7:0]  keycode_dir;
  logic [9:0]  Ball_X;
  logic [9:0]  Ball_Y;
  logic [3:0]  proj_active;
  logic [39:0] proj_x;
  logic [39:0] proj_y;
  logic        facing;
  logic        shot_fired;
  logic [7:0]  shot_count;

  int checks   = 0;
  int failures = 0;

  // Model state, in screen terms
  int  mAct[4];
  int  mX[4];
  int  mY[4];
  int  mDir[4];
  int  mFacing;
  int  mCool;
  int  mPrevShoot;
  int  mFired;
  int  mCount;
  int  shotsSeen;

  proj_ctrl dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycodeshoot (keycodeshoot),
    .keycode_dir  (keycode_dir),
    .Ball_X       (Ball_X),
    .Ball_Y       (Ball_Y),
    .proj_active  (proj_active),
    .proj_x       (proj_x),
    .proj_y       (proj_y),
    .facing       (facing),
    .shot_fired   (shot_fired),
    .shot_count   (shot_count)
  );

  always #5 frame_clk = ~frame_clk;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One frame of the game rules, applied to the model.
  task automatic modelStep(input logic rst, input logic [7:0] shoot,
                           input logic [7:0] dir, input int bx, input int by);
    int  req;
    int  freeSlot;
    int  nx;
    int  sx;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mAct[i] = 0; mX[i] = 0; mY[i] = 0; mDir[i] = 1;
      end
      mFacing = 1; mCool = 0; mPrevShoot = 0; mFired = 0; mCount = 0;
      return;
    end
    if (dir == 8'h04) mFacing = 0;
    else if (dir == 8'h07) mFacing = 1;
`ifdef PROJ_AUTOFIRE_EN
    req = (shoot == 8'h2C);
`else
    req = (shoot == 8'h2C) && !mPrevShoot;
`endif
    mPrevShoot = (shoot == 8'h2C);
    freeSlot = -1;
    for (int i = 3; i >= 0; i--) if (!mAct[i]) freeSlot = i;
    mFired = req && (mCool == 0) && (freeSlot >= 0);
    if (mFired) mCool = 8;
    else if (mCool > 0) mCool--;
    for (int i = 0; i < 4; i++) begin
      if (mAct[i]) begin
        nx = mDir[i] ? mX[i] + 12 : mX[i] - 12;
        if (nx < 0 || nx > 639) mAct[i] = 0;
        else mX[i] = nx;
      end
    end
    if (mFired) begin
      sx = mFacing ? bx + 32 : bx;
      if (sx > 639) sx = 639;
      mAct[freeSlot] = 1;
      mX[freeSlot]   = sx;
      mY[freeSlot]   = (by + 16) % 1024;
      mDir[freeSlot] = mFacing;
      mCount = (mCount + 1) % 256;
    end
  endtask

  task automatic compareAll();
    logic [3:0]  expAct;
    logic [39:0] expX;
    logic [39:0] expY;
    for (int i = 0; i < 4; i++) begin
      expAct[i]          = (mAct[i] != 0);
      expX[10*i +: 10]   = 10'(mX[i]);
      expY[10*i +: 10]   = 10'(mY[i]);
    end
    checkOutput("proj_active", 64'(proj_active), 64'(expAct));
    checkOutput("proj_x", 64'(proj_x), 64'(expX));
    checkOutput("proj_y", 64'(proj_y), 64'(expY));
    checkOutput("facing", 64'(facing), 64'(mFacing));
    checkOutput("shot_fired", 64'(shot_fired), 64'(mFired));
    checkOutput("shot_count", 64'(shot_count), 64'(mCount));
  endtask

  // Drive one frame away from the edge, step DUT and model, compare.
  task automatic applyStimulus(input logic rst, input logic [7:0] shoot,
                               input logic [7:0] dir, input int bx, input int by);
    @(negedge frame_clk);
    Reset        = rst;
    keycodeshoot = shoot;
    keycode_dir  = dir;
    Ball_X       = 10'(bx);
    Ball_Y       = 10'(by);
    @(posedge frame_clk);
    #1;
    modelStep(rst, shoot, dir, bx, by);
    compareAll();
    if (shot_fired === 1'b1) shotsSeen++;
  endtask

  initial begin
    Reset = 1'b1; keycodeshoot = 8'h00; keycode_dir = 8'h00;
    Ball_X = '0; Ball_Y = '0;
    shotsSeen = 0;

    // Reset state
    applyStimulus(1'b1, 8'h00, 8'h00, 0, 0);
    applyStimulus(1'b1, 8'h00, 8'h00, 0, 0);
    checkOutput("reset_active", 64'(proj_active), 64'd0);
    checkOutput("reset_facing", 64'(facing), 64'd1);
    checkOutput("reset_count", 64'(shot_count), 64'd0);

    // Basic spawn to the right and first move
    applyStimulus(1'b0, 8'h2C, 8'h00, 100, 250);
    checkOutput("spawn_x", 64'(proj_x[9:0]), 64'd132);
    checkOutput("spawn_y", 64'(proj_y[9:0]), 64'd266);
    checkOutput("spawn_pulse", 64'(shot_fired), 64'd1);
    checkOutput("spawn_count", 64'(shot_count), 64'd1);
    applyStimulus(1'b0, 8'h00, 8'h00, 100, 250);
    checkOutput("move_x", 64'(proj_x[9:0]), 64'd144);
    checkOutput("pulse_drop", 64'(shot_fired), 64'd0);

    // Reset mid-flight clears in one edge
    applyStimulus(1'b1, 8'h00, 8'h00, 100, 250);
    checkOutput("midreset_active", 64'(proj_active), 64'd0);

    // Holding the key for 20 frames
    shotsSeen = 0;
    for (int f = 0; f < 20; f++) applyStimulus(1'b0, 8'h2C, 8'h00, 100, 250);
`ifdef PROJ_AUTOFIRE_EN
    checkOutput("hold_shots", 64'(shotsSeen), 64'd3);
`else
    checkOutput("hold_shots", 64'(shotsSeen), 64'd1);
`endif

    // Presses at frames 0, 3, 9: the middle one falls inside the cooldown
    applyStimulus(1'b1, 8'h00, 8'h00, 0, 0);
    for (int f = 0; f < 10; f++)
      applyStimulus(1'b0, (f == 0 || f == 3 || f == 9) ? 8'h2C : 8'h00, 8'h00, 100, 250);
    checkOutput("spacing_count", 64'(shot_count), 64'd2);
    checkOutput("spacing_active", 64'(proj_active), 64'd3);

    // Facing left near the left edge: underflow retires, x holds
    applyStimulus(1'b1, 8'h00, 8'h00, 0, 0);
    applyStimulus(1'b0, 8'h2C, 8'h04, 10, 40);
    checkOutput("left_facing", 64'(facing), 64'd0);
    checkOutput("left_spawn_x", 64'(proj_x[9:0]), 64'd10);
    applyStimulus(1'b0, 8'h00, 8'h00, 10, 40);
    checkOutput("underflow_active", 64'(proj_active[0]), 64'd0);
    checkOutput("underflow_x", 64'(proj_x[9:0]), 64'd10);

    // Right edge: spawn at 630, next move overshoots
    applyStimulus(1'b1, 8'h00, 8'h00, 0, 0);
    applyStimulus(1'b0, 8'h2C, 8'h07, 598, 40);
    checkOutput("edge_spawn_x", 64'(proj_x[9:0]), 64'd630);
    applyStimulus(1'b0, 8'h00, 8'h00, 598, 40);
    checkOutput("edge_retire", 64'(proj_active[0]), 64'd0);

    // Randomized frames against the model
    applyStimulus(1'b1, 8'h00, 8'h00, 0, 0);
    for (int f = 0; f < 600; f++) begin
      logic [7:0] s;
      logic [7:0] d;
      int         bx;
      case ($urandom_range(0, 3))
        0, 1:    s = 8'h2C;
        2:       s = 8'h00;
        default: s = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0:       d = 8'h04;
        1:       d = 8'h07;
        default: d = 8'($urandom_range(0, 255));
      endcase
      bx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(600, 1023))
                                       : int'($urandom_range(0, 639));
      applyStimulus(($urandom_range(0, 63) == 0), s, d, bx,
                    int'($urandom_range(0, 1023)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proj_ctrl.md
# proj_ctrl

Projectile controller downstream of the player-motion stage. It consumes the player position (Ball_X/Ball_Y), the movement keycode and the shoot keycode once per frame. It owns a fixed pool of projectile slots: spawns projectiles at the player, moves them horizontally each frame and retires them at the screen edges. Its outputs feed the sprite renderer and game logic.

## Interface
- NUM_PROJ, 4: number of projectile slots.
- PROJ_SPEED, 12: pixels moved per frame.
- COOLDOWN, 8: frames between accepted shots.
- X_MIN, 0 / X_MAX, 639: legal projectile X range, inclusive.
- SPAWN_X_OFFSET, 32 / SPAWN_Y_OFFSET, 16: spawn offset from player origin.
- SHOOT_KEY, 8'h2C: shoot keycode (space).

Ports:
- frame_clk  in  1  frame clock, one edge per video frame
- Reset  in  1  synchronous, active-high
- keycodeshoot  in  8  shoot key channel
- keycode_dir  in  8  movement key channel (8'h04 = A, 8'h07 = D)
- Ball_X, Ball_Y  in  10  player position
- proj_active  out  NUM_PROJ  slot i is in flight
- proj_x, proj_y  out  NUM_PROJ*10  packed; slot i occupies bits [10i+9:10i]
- facing  out  1  1 = right, 0 = left
- shot_fired  out  1  one-frame pulse when a spawn is accepted
- shot_count  out  8  accepted shots, wraps 255 -> 0

## Operation
- **Reset state**
  - proj_active = 0, all proj_x and proj_y = 0.
  - facing = 1, shot_fired = 0, shot_count = 0.
  - Cooldown counter = 0, key history = 0.
- **Facing**
  - keycode_dir 8'h04 sets left; 8'h07 sets right; any other value holds.
  - The new facing takes effect for a spawn in the same frame.
- **Fire request**
  - Condition: keycodeshoot == SHOOT_KEY and the previous frame's value != SHOOT_KEY (rising edge).
- **Accept**
  - Requires a fire request, cooldown == 0 and at least one slot with proj_active == 0.
  - The lowest-index free slot is allocated.
- **Spawn**
  - X = Ball_X + SPAWN_X_OFFSET when facing right, Ball_X when facing left.
  - Spawn X is clamped to X_MAX. Y = Ball_Y + SPAWN_Y_OFFSET.
  - The slot latches its own direction at spawn.
- **Accept side effects**
  - shot_fired = 1 for that frame, shot_count increments, cooldown loads COOLDOWN.
- **Reject**
  - A rejected request is dropped, not queued.
  - Cooldown is not reloaded and shot_fired stays 0.
- **Cooldown**
  - Decrements once per frame while nonzero; saturates at 0.
- **Slot FSM**
  - States: IDLE (active = 0) and FLY (active = 1).
  - IDLE -> FLY on allocation.
  - In FLY, the slot computes next X = x ± PROJ_SPEED in 11 bits.
  - FLY -> IDLE when next X < X_MIN (including underflow) or > X_MAX; x and y then hold their last values.
  - Otherwise x takes next X. y never changes in flight.
- **Simultaneous events**
  - Free-slot selection uses the registered proj_active. A slot retiring this frame becomes allocatable next frame, never the same frame.
  - A slot spawned this frame does not move this frame.
- **Reset mid-flight**
  - All slots go IDLE and cooldown clears on that edge.

## Timing
- All inputs are sampled on the frame_clk rising edge n; all outputs are registered.
- A spawn accepted at edge n is visible at edge n with the spawn position. The first movement happens at edge n+1.
- Retirement: proj_active drops at the edge where the out-of-range next X is computed.
- Minimum spacing between accepted shots is COOLDOWN+1 frames: after loading at n, cooldown reaches 0 at n+COOLDOWN and accept is possible at n+COOLDOWN+1 given a new edge.
- Arithmetic: unsigned 10-bit positions with 11-bit intermediates. Overflow or underflow counts as out-of-range.

## Configuration
- PROJ_AUTOFIRE_EN defined: the fire request is level-sensitive. Holding SHOOT_KEY requests every frame, so a shot is accepted whenever cooldown == 0 and a slot is free.
- PROJ_AUTOFIRE_EN undefined: rising-edge request only, as specified above.

## Structure
- **proj_pkg**
  - dir_e typedef: DIR_LEFT = 0, DIR_RIGHT = 1.
  - Key constants KEY_A, KEY_D, KEY_SPACE.
  - Screen bound constants shared with the player-motion stage.
- **proj_slot** sub-module, instantiated NUM_PROJ times.
  - Holds one slot's active, x, y and dir.
  - Performs the spawn load, the move and the retire check.
- **Top level**
  - Owns facing, key history, cooldown, the priority free-slot encoder and the counters.

## Test plan
- Reset; Ball_X=100, Ball_Y=250, facing right; press SHOOT_KEY one frame -> slot0 active, x=132, y=266, shot_fired pulse, shot_count=1; next frame x=144.
- Hold SHOOT_KEY 20 frames -> exactly one shot. With PROJ_AUTOFIRE_EN -> 3 shots, at frames 0, 9 and 18.
- Press at frame 0, then at frame 3 -> second press dropped. Press at frame 9 -> slot1 allocated.
- keycode_dir=8'h04, Ball_X=10, fire -> spawn x=10. Next frame 10-12 underflows -> slot retires, x stays 10.
- Slot at x=630 facing right -> next frame proj_active[i] = 0.
- Fire 4 spaced shots -> all slots full; 5th press dropped, shot_count=4. After slot0 retires, the next press is allocated to slot0. Reset mid-flight clears everything in one edge.
